// File: rtl/spi_ep_slave.sv
// SPI responder front-end (CPOL=1, CPHA=1, MSB first) terminated in the clk domain.
// Synchronizes the SPI pins, tracks the endpoint select, deserializes received
// bytes and serializes transmit bytes, exposing a byte-level valid/ack stream.
module spi_ep_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic [7:0] spi_csel,
  output logic       spi_miso,
  output logic [7:0] ep_sel,
  output logic       ep_start,
  output logic       ep_stop,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [7:0] byte_idx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  logic       sclk_s1_r;
  logic       sclk_s2_r;
  logic       sclk_s3_r;
  logic       mosi_s1_r;
  logic       mosi_s2_r;
  logic [7:0] csel_s1_r;
  logic [7:0] csel_s2_r;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] tx_shift_r;
  logic [7:0] rx_shift_r;

  logic       sclk_fall_s;
  logic       sclk_rise_s;
  logic       sel_change_s;
  logic [7:0] rx_next_s;

  // Two-flop synchronizers; sclk gets a third stage for edge detection.
  // sclk resets high so the idle level never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1_r <= 1'b1;
      sclk_s2_r <= 1'b1;
      sclk_s3_r <= 1'b1;
      mosi_s1_r <= 1'b0;
      mosi_s2_r <= 1'b0;
      csel_s1_r <= 8'h00;
      csel_s2_r <= 8'h00;
    end else begin
      sclk_s1_r <= spi_sclk;
      sclk_s2_r <= sclk_s1_r;
      sclk_s3_r <= sclk_s2_r;
      mosi_s1_r <= spi_mosi;
      mosi_s2_r <= mosi_s1_r;
      csel_s1_r <= spi_csel;
      csel_s2_r <= csel_s1_r;
    end
  end

  // Edge detect on synchronized sclk, select-change detect, next rx byte.
  always_comb begin
    sclk_fall_s  = sclk_s3_r & ~sclk_s2_r;
    sclk_rise_s  = ~sclk_s3_r & sclk_s2_r;
    sel_change_s = (csel_s2_r != ep_sel);
    rx_next_s    = {rx_shift_r[6:0], mosi_s2_r};
  end

  // Select tracking and byte FSM; a select change overrides any bit activity
  // and throws away a partially received byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 8'h00;
      rx_shift_r <= 8'h00;
      spi_miso   <= 1'b0;
      ep_sel     <= 8'h00;
      ep_start   <= 1'b0;
      ep_stop    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      byte_idx   <= 8'h00;
      tx_ack     <= 1'b0;
    end else begin
      ep_start <= 1'b0;
      ep_stop  <= 1'b0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      if (sel_change_s) begin
        ep_sel     <= csel_s2_r;
        ep_start   <= (csel_s2_r != 8'h00);
        ep_stop    <= (ep_sel != 8'h00);
        bit_cnt_r  <= 3'd0;
        byte_idx   <= 8'h00;
        rx_shift_r <= 8'h00;
        if (csel_s2_r == 8'h00) begin
          state_r  <= ST_IDLE;
          spi_miso <= 1'b0;
        end else begin
          state_r  <= ST_LOAD;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            spi_miso <= 1'b0;
          end
          ST_LOAD: begin
            // A rise before the byte's first fall is ignored here.
            if (sclk_fall_s) begin
              if (tx_valid) begin
                tx_shift_r <= tx_data;
                spi_miso   <= tx_data[7];
                tx_ack     <= 1'b1;
              end else begin
                tx_shift_r <= IDLE_BYTE;
                spi_miso   <= IDLE_BYTE[7];
              end
              state_r <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sclk_fall_s) begin
              spi_miso   <= tx_shift_r[6];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else if (sclk_rise_s) begin
              rx_shift_r <= rx_next_s;
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_next_s;
                if (byte_idx != 8'hFF) begin
                  byte_idx <= byte_idx + 8'd1;
                end
                state_r <= ST_LOAD;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_ep_slave.md
# spi_ep_slave

SPI responder front-end that terminates the external SPI bus (CPOL=1, CPHA=1, MSB first) inside the chip, in the `clk` domain. It synchronizes `spi_sclk`, `spi_mosi` and the 8-bit endpoint select `spi_csel` and deserializes received bytes. It serializes transmit bytes onto `spi_miso` and presents a byte-level valid/ack stream tagged with the active endpoint number to the endpoint logic behind it. Endpoint 0 is the idle/no-select code.

## Interface
- `IDLE_BYTE`, default 8'h00: byte shifted out when the endpoint has no transmit data ready at byte start.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `spi_sclk` input 1: SPI clock, asynchronous to `clk`, idles high.
- `spi_mosi` input 1: SPI data in, asynchronous.
- `spi_csel` input 8: endpoint select, asynchronous; 0 = deselected.
- `spi_miso` output 1: SPI data out, registered.
- `ep_sel` output 8: synchronized active endpoint.
- `ep_start` output 1: one-cycle pulse when `ep_sel` takes a new non-zero value.
- `ep_stop` output 1: one-cycle pulse when `ep_sel` leaves a non-zero value.
- `rx_valid` output 1: one-cycle pulse, `rx_data` holds a complete received byte.
- `rx_data` output 8: last received byte.
- `byte_idx` output 8: index of the current byte within the selection, 0-based, saturates at 255.
- `tx_data` input 8: next byte to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ack` output 1: one-cycle pulse when `tx_data` is latched into the shifter.

## Operation
- Sync: `spi_sclk`, `spi_mosi` and each `spi_csel` bit pass through 2 flops (s1, s2). A third sclk flop (s3) is used for edge detect: fall = s3 & ~s2, rise = ~s3 & s2.
- Select tracking: `ep_sel` loads the synchronized csel when it differs from `ep_sel`.
  - Non-zero to different non-zero: `ep_stop` and `ep_start` pulse in the same cycle.
  - Any change clears the bit counter, clears `byte_idx`, and discards any partial byte (no `rx_valid`).
- States: IDLE (`ep_sel`==0), LOAD (selected, bit counter 0, waiting for the first fall), SHIFT (bits 1..7). All edges are ignored in IDLE.
- LOAD, on fall:
  - If `tx_valid`: latch `tx_data` into the tx shifter and pulse `tx_ack`; otherwise latch `IDLE_BYTE`.
  - Drive the MSB on `spi_miso`; go to SHIFT.
- SHIFT, on fall: shift the tx shifter left and drive the next bit.
- Every rise while selected: shift s2 of mosi into the rx shifter at the LSB and increment the bit counter (3 bits).
- 8th rise:
  - Pulse `rx_valid` with the full byte.
  - `byte_idx` increments, saturating at 255, in the same cycle as `rx_valid`.
  - Return to LOAD.
- `spi_miso` holds its value between falls. It is forced to 0 in IDLE.
- A rise with no preceding fall in the byte (first edge after select is a rise) is ignored.

## Timing
- Reset values:
  - `spi_miso`=0, `ep_sel`=0, `ep_start`=0, `ep_stop`=0, `rx_valid`=0, `rx_data`=0, `byte_idx`=0, `tx_ack`=0.
  - Sync flops reset to sclk=1, mosi=0, csel=0.
  - State IDLE.
- Edge latency: pin edge to detect is 2-3 `clk` cycles. `spi_miso` updates 1 cycle after a detected fall, i.e. ≤4 cycles after the pin fall.
- `rx_valid` asserts 1 cycle after the 8th detected rise.
- `ep_sel` updates 3 cycles after a `spi_csel` change.
- Constraints:
  - SCLK high and low phases are each ≥4 `clk` cycles.
  - `spi_csel` is changed only while `spi_sclk` is high and is stable ≥4 cycles before the first fall.
- `tx_data`/`tx_valid` are sampled in the detect cycle of the byte's first fall. The endpoint must present the next byte within 3 cycles of `rx_valid`, or at select.
- Reset asserted mid-byte: immediate return to reset values. The partial byte is lost and no pulses are generated on release.

## Test plan
- Select EP1, master sends 0x77 with endpoint `tx_data`=0x8F valid -> `ep_start` one pulse, `ep_sel`=1, master reads 0x8F, `rx_valid` with `rx_data`=0x77, `byte_idx` 0→1, one `tx_ack`.
- EP1, 5 bytes 0x77,0x88,0x99,0x00,0x07 with endpoint echoing received bytes delayed by 2 after preamble 0x8F,0x2A -> master reads 0x8F,0x2A,0x77,0x88,0x99; exactly 5 `rx_valid` and 5 `tx_ack`.
- `tx_valid`=0 at byte start -> master reads `IDLE_BYTE` (0x00), no `tx_ack`, `rx_valid` still pulses.
- Switch `spi_csel` 1→0 after 4 bits, then 0→2 -> no `rx_valid`, `ep_stop` then `ep_start`, `byte_idx`=0. Next full byte 0x04 is received correctly on EP2.
- EP1, 300 bytes 0,1,2,... -> `rx_data` matches each byte, `byte_idx` saturates at 255 and stays there; deselect -> `ep_stop`, `spi_miso`=0.
- Assert `reset` during bit 5 of a byte -> all outputs at reset values next cycle. After release, a fresh select and byte transfer complete normally.
